seq_chunk_adder: RTL and testbench

//   Parametrised multi-cycle adder: WIDTH-bit A+B+Cin computed CHUNK bits per

---
 rtl/seq_chunk_adder.sv | 122 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder: A+B+Cin evaluated CHUNK bits per clock through a single ripple slice.
// Optional SEQ_ADD_OVF_EN adds the ovf port carrying signed two's-complement overflow.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SEQ_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) ? 1'b1 : ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             last;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CHUNK:0]   slice;

  // One CHUNK-bit ripple slice; bit CHUNK of the result is the slice carry-out.
  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  assign last  = (idx == IDX_W'(NCHUNK - 1));
  assign slice = chunk_add(a_r[idx*CHUNK +: CHUNK], b_r[idx*CHUNK +: CHUNK], carry);
  assign busy  = (state == ADD);
  assign done  = (state == DONE);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ADD;
        end
      end
      ADD: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        // Back-to-back requests skip IDLE entirely.
        if (start) begin
          accept   = 1'b1;
          state_nx = ADD;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Captured operands are data only and carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        carry <= cin;
        idx   <= '0;
        sum   <= '0;
      end else if (state == ADD) begin
        sum[idx*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
        carry <= slice[CHUNK];
        idx   <= last ? '0 : idx + 1'b1;
        if (last) begin
          cout <= slice[CHUNK];
`ifdef SEQ_ADD_OVF_EN
          // Carry into the MSB is a^b^sum at that bit; XOR with carry out.
          ovf  <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ slice[CHUNK-1] ^ slice[CHUNK];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: 16/4 main instance plus 8/8 and 8/1 instances.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        start8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8a, done8a, cout8a, busy8b, done8b, cout8b;
  logic [7:0]  sum8a, sum8b;
`ifdef SEQ_ADD_OVF_EN
  logic        ovf16, ovf8a, ovf8b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16),
`ifdef SEQ_ADD_OVF_EN
    .ovf(ovf16),
`endif
    .cout(cout16));

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8a (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8a), .done(done8a), .sum(sum8a),
`ifdef SEQ_ADD_OVF_EN
    .ovf(ovf8a),
`endif
    .cout(cout8a));

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut8b (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8b), .done(done8b), .sum(sum8b),
`ifdef SEQ_ADD_OVF_EN
    .ovf(ovf8b),
`endif
    .cout(cout8b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the 16-bit instance; inputs are scrambled after accept.
  task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                      output logic [15:0] s, output logic co, output logic ov,
                      output int lat, output int bc);
    a16 = av; b16 = bv; cin16 = cv; start16 = 1'b1;
    lat = -1; bc = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      if (busy16) bc++;
      if (done16) begin
        lat = n;
        break;
      end
    end
    s  = sum16;
    co = cout16;
`ifdef SEQ_ADD_OVF_EN
    ov = ovf16;
`else
    ov = 1'b0;
`endif
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     output logic [7:0] sa, output logic ca, output int la,
                     output logic [7:0] sb, output logic cb, output int lb);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    la = -1; lb = -1; sa = '0; sb = '0; ca = 1'b0; cb = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      start8 = 1'b0;
      a8 = ~av; b8 = ~bv; cin8 = ~cv;
      if (done8a && la < 0) begin
        la = n; sa = sum8a; ca = cout8a;
      end
      if (done8b && lb < 0) begin
        lb = n; sb = sum8b; cb = cout8b;
      end
      if (la >= 0 && lb >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start16 = 1'b1; start8 = 1'b1;
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
    step(); step(); step();
    total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL reset_busy16 got=%b exp=0", busy16); end
    total++; if (done16 !== 1'b0) begin bad++; $display("FAIL reset_done16 got=%b exp=0", done16); end
    total++; if (sum16 !== 16'h0) begin bad++; $display("FAIL reset_sum16 got=%h exp=0000", sum16); end
    total++; if (cout16 !== 1'b0) begin bad++; $display("FAIL reset_cout16 got=%b exp=0", cout16); end
    total++; if ({busy8a, done8a, busy8b, done8b} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl8 got=%b exp=0000", {busy8a, done8a, busy8b, done8b});
    end
`ifdef SEQ_ADD_OVF_EN
    total++; if (ovf16 !== 1'b0) begin bad++; $display("FAIL reset_ovf16 got=%b exp=0", ovf16); end
`endif
    rst = 1'b0; start16 = 1'b0; start8 = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [15:0] s; logic co, ov; int lat, bc;
    op16(16'h0001, 16'h0002, 1'b0, s, co, ov, lat, bc);
    total++; if (s !== 16'h0003) begin bad++; $display("FAIL basic_sum got=%h exp=0003", s); end
    total++; if (co !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b exp=0", co); end
    total++; if (lat !== 5) begin bad++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    total++; if (bc !== 4) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
    step();
    total++; if (done16 !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done16); end
    total++; if (sum16 !== 16'h0003) begin bad++; $display("FAIL basic_sum_held got=%h exp=0003", sum16); end
  endtask

  task automatic test_carry();
    logic [15:0] s; logic co, ov; int lat, bc;
    op16(16'hFFFF, 16'h0001, 1'b0, s, co, ov, lat, bc);
    total++; if ({co, s} !== 17'h10000) begin bad++; $display("FAIL carry_ripple got=%b_%h exp=1_0000", co, s); end
    op16(16'hFFFF, 16'hFFFF, 1'b1, s, co, ov, lat, bc);
    total++; if ({co, s} !== 17'h1FFFF) begin bad++; $display("FAIL carry_max got=%b_%h exp=1_ffff", co, s); end
    op16(16'h1234, 16'hEDCB, 1'b1, s, co, ov, lat, bc);
    total++; if ({co, s} !== 17'h10000) begin bad++; $display("FAIL carry_cin got=%b_%h exp=1_0000", co, s); end
    op16(16'hABCD, 16'h1234, 1'b0, s, co, ov, lat, bc);
    total++; if ({co, s} !== 17'h0BE01) begin bad++; $display("FAIL carry_mixed got=%b_%h exp=0_be01", co, s); end
  endtask

  task automatic test_back_to_back();
    int first, second, b2;
    logic [15:0] s1;
    logic c1;
    first = -1; second = -1; b2 = 0; s1 = '0; c1 = 1'b0;
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; start16 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b1;
      if (done16) begin
        first = n; s1 = sum16; c1 = cout16;
        break;
      end
    end
    total++; if (first !== 5) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=5", first); end
    total++; if ({c1, s1} !== 17'h02345) begin bad++; $display("FAIL b2b_first_sum got=%b_%h exp=0_2345", c1, s1); end
    for (int n = 1; n <= 20; n++) begin
      step();
      start16 = 1'b0;
      if (n == 1) b2 = int'(busy16);
      if (done16) begin
        second = n;
        break;
      end
    end
    total++; if (b2 !== 1) begin bad++; $display("FAIL b2b_direct_add got=%0d exp=1", b2); end
    total++; if (second !== 5) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=5", second); end
    total++; if ({cout16, sum16} !== 17'h10001) begin
      bad++; $display("FAIL b2b_second_sum got=%b_%h exp=1_0001", cout16, sum16);
    end
    step();
  endtask

  task automatic test_abort();
    logic [15:0] s; logic co, ov; int lat, bc, dn;
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    step();
    rst = 1'b1; start16 = 1'b1; a16 = 16'hFFFF;
    step();
    total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy16); end
    total++; if (done16 !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done16); end
    total++; if (sum16 !== 16'h0) begin bad++; $display("FAIL abort_sum got=%h exp=0000", sum16); end
    total++; if (cout16 !== 1'b0) begin bad++; $display("FAIL abort_cout got=%b exp=0", cout16); end
    rst = 1'b0; start16 = 1'b0;
    dn = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (done16 || busy16) dn++;
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", dn); end
    op16(16'h00FF, 16'h0F01, 1'b0, s, co, ov, lat, bc);
    total++; if ({co, s} !== 17'h01000) begin bad++; $display("FAIL abort_restart_sum got=%b_%h exp=0_1000", co, s); end
    total++; if (lat !== 5) begin bad++; $display("FAIL abort_restart_latency got=%0d exp=5", lat); end
  endtask

`ifdef SEQ_ADD_OVF_EN
  task automatic test_ovf();
    logic [15:0] s; logic co, ov; int lat, bc;
    op16(16'h7FFF, 16'h0001, 1'b0, s, co, ov, lat, bc);
    total++; if ({ov, co, s} !== 18'h28000) begin bad++; $display("FAIL ovf_pos got=%b%b_%h exp=10_8000", ov, co, s); end
    op16(16'h8000, 16'h8000, 1'b0, s, co, ov, lat, bc);
    total++; if ({ov, co, s} !== 18'h30000) begin bad++; $display("FAIL ovf_neg got=%b%b_%h exp=11_0000", ov, co, s); end
    op16(16'h0001, 16'h0001, 1'b0, s, co, ov, lat, bc);
    total++; if ({ov, co, s} !== 18'h00002) begin bad++; $display("FAIL ovf_none got=%b%b_%h exp=00_0002", ov, co, s); end
  endtask
`endif

  task automatic test_width8();
    logic [7:0] vals [11];
    logic [7:0] sa, sb;
    logic ca, cb;
    int la, lb;
    logic [8:0] exp9;
    vals = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h55, 8'h7F, 8'h80, 8'hAA, 8'hF0, 8'hFE, 8'hFF};
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < 11; j++) begin
        for (int c = 0; c < 2; c++) begin
          exp9 = {1'b0, vals[i]} + {1'b0, vals[j]} + 9'(c);
          op8(vals[i], vals[j], 1'(c), sa, ca, la, sb, cb, lb);
          total++; if ({ca, sa} !== exp9) begin
            bad++; $display("FAIL w8c8_sum a=%h b=%h cin=%0d got=%h exp=%h", vals[i], vals[j], c, {ca, sa}, exp9);
          end
          total++; if ({cb, sb} !== exp9) begin
            bad++; $display("FAIL w8c1_sum a=%h b=%h cin=%0d got=%h exp=%h", vals[i], vals[j], c, {cb, sb}, exp9);
          end
          total++; if (la !== 2) begin bad++; $display("FAIL w8c8_latency got=%0d exp=2", la); end
          total++; if (lb !== 9) begin bad++; $display("FAIL w8c1_latency got=%0d exp=9", lb); end
        end
      end
    end
  endtask

  initial begin
    start16 = 1'b0; start8 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_abort();
`ifdef SEQ_ADD_OVF_EN
    test_ovf();
`endif
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
